sum8bit_ctrl: RTL
=================

# sum8bit_ctrl

Sequencing and arbitration controller around one `sum4bit` instance (x0, x1 4-bit in; o 5-bit out). Two requesters share the adder. The controller performs each 8-bit add nibble-serially: low nibble, high nibble, then a carry-fix pass on the same adder. It returns a 9-bit sum. It sits between the requesting units and the single shared 4-bit adder, and is the only driver of that adder's inputs.

## Interface
- FIRST, 0, requester that wins the first tie after reset (0 or 1)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request; held until its done
- a0, b0  in  8 each  requester 0 operands
- req1  in  1  requester 1 request
- a1, b1  in  8 each  requester 1 operands
- grant  out  2  one-hot, registered; pulses for one cycle when a requester is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; sum valid
- done_id  out  1  requester that owns the current done
- sum  out  9  result {carry, 8-bit sum}; held until next done

## Operation
- States: IDLE → LO → HI → FIX → DONE → IDLE. Unconditional after IDLE.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant it.
  - Both req: grant the requester not served last. The last-served pointer resets so that FIRST wins the first tie.
  - On grant, capture the granted a/b into internal registers and move to LO. Operands may change after the grant cycle.
- LO: adder x0=a[3:0], x1=b[3:0]. Register lo=o[3:0] and c0=o[4].
- HI: x0=a[7:4], x1=b[7:4]. Register hs=o[4:0].
- FIX: x0=hs[3:0], x1={3'b000,c0}. Register sum={hs[4] | o[4], o[3:0], lo}. The FIX pass always executes, even when c0=0, so latency is fixed. hs[4] and o[4] are never both 1.
- DONE: done=1, done_id=owner. Update the last-served pointer to the owner.
- Adder inputs are 0 in IDLE and DONE.
- The result is exact mod 2^9: sum = a + b for all 8-bit a, b.
- Reset values: state IDLE, grant=2'b00, busy=0, done=0, done_id=0, sum=0, operand and partial registers 0, pointer per FIRST.
- Reset in any state aborts the operation. No done is produced and the pending request is not remembered. If req is still high after reset, it is re-arbitrated in IDLE.
- Requester rule: req must be low in the first cycle after its done. A req still high in IDLE is treated as a new transaction.
- A req that drops before being granted is simply not served; there is no penalty.

## Timing
- Req high at edge E0 while in IDLE:
  - grant during cycle E0→E1 (state LO)
  - HI at E1→E2
  - FIX at E2→E3
  - done and sum valid at E3→E4
  - IDLE at E4
- Latency from request sampled to done is 4 cycles. Occupancy is 5 cycles per transaction, IDLE included.
- Back-to-back with both requesting continuously: grants alternate, one done every 5 cycles.
- sum changes only at the edge entering DONE.
- busy equals state != IDLE, registered.

## Test plan
- Single add: req0, a0=0x0F, b0=0x01 → grant=01 one cycle later; done 4 cycles after request with done_id=0, sum=0x010.
- Maximum: req1, a1=0xFF, b1=0xFF → sum=0x1FE, done_id=1. Carry-fix path: a=0xF8, b=0x08 → sum=0x100 (c0=1 ripples through FIX). Exhaustive 65536-pair sweep on requester 0 → every sum == a+b.
- Tie and fairness: after reset with FIRST=0, req0 and req1 held together (a0=0x10,b0=0x20; a1=0x03,b1=0x04) → first done_id=0 sum=0x030, next done_id=1 sum=0x007, 5 cycles apart. Strict alternation over 8 transactions.
- Operand capture: change a0 from 0x11 to 0xEE in the cycle after grant, with b0=0x22 → sum=0x033.
- Reset mid-operation: assert reset during HI → next cycle busy=0, grant=0, done=0, sum=0. No done is seen for the aborted request. With req still high, a fresh grant follows the reset release.
- Protocol: hold req0 for one cycle past done → a second transaction is granted and completes with correct sum. With no req, busy stays 0 and outputs are stable for 20 cycles.

Source files
------------

// File: rtl/sum8bit_ctrl.sv
// Two-requester controller sharing one 4-bit adder: each 8-bit add runs
// low nibble, high nibble, then a carry-fix pass, giving a 9-bit sum.

module sum4bit (
   input  logic [3:0] x0,
   input  logic [3:0] x1,
   output logic [4:0] o
);
   assign o = {1'b0, x0} + {1'b0, x1};
endmodule

module sum8bit_ctrl #(
   parameter bit FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] a0,
   input  logic [7:0] b0,
   input  logic       req1,
   input  logic [7:0] a1,
   input  logic [7:0] b1,
   output logic [1:0] grant,
   output logic       busy,
   output logic       done,
   output logic       done_id,
   output logic [8:0] sum
);
   typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;

   state_t     state;
   logic [7:0] a_reg;
   logic [7:0] b_reg;
   logic [3:0] lo;
   logic       c0;
   logic [4:0] hs;
   logic       owner;
   logic       last;
   logic       pick;
   logic [3:0] x0;
   logic [3:0] x1;
   logic [4:0] o;

   // On a tie the requester not served last wins; otherwise whoever asks.
   always_comb begin
      pick = req1;
      if (req0 && req1) pick = ~last;
   end

   always_comb begin
      x0 = 4'd0;
      x1 = 4'd0;
      case (state)
         LO: begin
            x0 = a_reg[3:0];
            x1 = b_reg[3:0];
         end
         HI: begin
            x0 = a_reg[7:4];
            x1 = b_reg[7:4];
         end
         FIX: begin
            x0 = hs[3:0];
            x1 = {3'b000, c0};
         end
         default: begin
            x0 = 4'd0;
            x1 = 4'd0;
         end
      endcase
   end

   sum4bit adder (
      .x0 (x0),
      .x1 (x1),
      .o  (o)
   );

   // The high-nibble carry and the fix-pass carry are mutually exclusive,
   // so OR-ing them gives the exact ninth bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         grant   <= 2'b00;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= 1'b0;
         sum     <= 9'd0;
         a_reg   <= 8'd0;
         b_reg   <= 8'd0;
         lo      <= 4'd0;
         c0      <= 1'b0;
         hs      <= 5'd0;
         owner   <= 1'b0;
         last    <= ~FIRST;
      end else begin
         grant <= 2'b00;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner <= pick;
                  grant <= pick ? 2'b10 : 2'b01;
                  a_reg <= pick ? a1 : a0;
                  b_reg <= pick ? b1 : b0;
                  busy  <= 1'b1;
                  state <= LO;
               end
            end
            LO: begin
               lo    <= o[3:0];
               c0    <= o[4];
               state <= HI;
            end
            HI: begin
               hs    <= o;
               state <= FIX;
            end
            FIX: begin
               sum     <= {hs[4] | o[4], o[3:0], lo};
               done    <= 1'b1;
               done_id <= owner;
               state   <= DONE;
            end
            DONE: begin
               last  <= owner;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
